vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between the VGA display fetch and the paint writer.
- Runs on the 50 MHz system clock and time-slices each 25 MHz pixel period into a display slot and a writer slot.
- Gives the writer every cycle during blanking.
- Owns a clear-screen sequencer that fills the framebuffer with one colour.
- Sits between the VGA driver (coords, PXL_CLK), the paint logic and the RAM.

Parameters:
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- SCALE_SHIFT, 2, screen-to-framebuffer coordinate right-shift (640x480 -> 160x120)
- ADDR_W, 15, RAM address width (must satisfy 2^ADDR_W >= FB_W*FB_H)

Ports:
- CLK_IN  in  1  50 MHz system clock
- RST_N  in  1  asynchronous active-low reset
- PXL_CLK  in  1  pixel clock from VGA driver, a register of CLK_IN (toggles every cycle)
- VID_ACTIVE  in  1  driver's visible-area flag
- X_IN  in  10  screen x
- Y_IN  in  10  screen y
- PIX_OUT  out  8  fetched pixel (RRRGGGBB)
- WR_VALID  in  1  paint write request
- WR_READY  out  1  write accepted this cycle when WR_VALID is also high
- WR_X  in  8  framebuffer x
- WR_Y  in  7  framebuffer y
- WR_DATA  in  8  colour to write
- CLR_REQ  in  1  start clear (level or pulse)
- CLR_COLOR  in  8  fill colour
- CLR_BUSY  out  1  clear in progress
- RAM_ADDR  out  ADDR_W  RAM address
- RAM_WE  out  1  RAM write enable
- RAM_WDATA  out  8  RAM write data
- RAM_RDATA  in  8  RAM read data, valid the cycle after the address

Behaviour:
- Reset values:
  - PIX_OUT=0, CLR_BUSY=0, state=IDLE, clear counter=0, pipeline valid flag=0.
  - WR_READY, RAM_WE, RAM_ADDR and RAM_WDATA are all 0 while RST_N is low.
- Slot rule (per CLK_IN cycle):
  - Display slot: PXL_CLK==1 && VID_ACTIVE==1. Drive RAM_ADDR = (Y_IN>>SCALE_SHIFT)*FB_W + (X_IN>>SCALE_SHIFT), RAM_WE=0. Register rd_pending=1.
  - Writer slot: every other cycle. During active video that is one cycle per pixel; during blanking it is every cycle.
- Display return:
  - In the cycle after a display slot, PIX_OUT <= RAM_RDATA at the end of that cycle.
  - If the previous cycle was not a display slot, PIX_OUT holds; it is forced to 0 at the first edge where rd_pending=0 and PXL_CLK==0.
  - Net latency is exactly one pixel period: PIX_OUT corresponds to the coordinates presented in the previous pixel period. The top level compensates.
- Address arithmetic:
  - Computed at ADDR_W bits; the multiply is by a constant.
  - X_IN/Y_IN are valid by construction when VID_ACTIVE=1.
- FSM states:
  - IDLE: CLR_REQ=1 -> latch CLR_COLOR, counter=0, go CLEAR; CLR_BUSY=1 from the next cycle.
  - CLEAR: each writer slot drives RAM_WE=1, RAM_ADDR=counter, RAM_WDATA=latched colour, then counter+1. After writing address FB_W*FB_H-1, go IDLE; CLR_BUSY=0 on the following cycle. CLR_REQ is ignored while in CLEAR.
- Writer handshake:
  - WR_READY = writer slot && state==IDLE && CLR_REQ==0 (clear has priority over a same-cycle write).
  - Transfer = WR_VALID && WR_READY. The RAM write is issued in the same cycle at address WR_Y*FB_W + WR_X.
  - If WR_X >= FB_W or WR_Y >= FB_H, the transfer completes (READY honoured) but RAM_WE stays 0 (dropped).
  - WR_VALID may rise or fall in any cycle; no data is held across cycles.
- Idle writer slot: RAM_WE=0, RAM_ADDR=0.
- Reset mid-clear: aborts immediately; state IDLE, CLR_BUSY=0, counter=0. Partially cleared contents are left as-is.
- Clear duration: FB_W*FB_H writer slots, between 19200 and 38400 cycles depending on blanking.

Optional Feature:
- Macro: VGA_FB_ARB_STATS_EN.
- Defined:
  - Adds outputs WR_CNT[15:0] and DROP_CNT[7:0], both reset to 0.
  - WR_CNT increments on each in-range accepted write and wraps.
  - DROP_CNT increments on each dropped transfer and saturates at 255.
  - Clear writes are not counted.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package vga_pkg:
  - constants FB_W, FB_H, SCALE_SHIFT, ADDR_W, PIXEL_W=8;
  - FSM state enum (IDLE, CLEAR);
  - pixel_t (8-bit RRRGGGBB).
- One natural sub-module, vga_fb_clear_seq: the clear FSM plus address counter, with a slot-grant input and a write-strobe output.

Test Plan:
- Reset: hold RST_N=0 with random inputs -> PIX_OUT=0, RAM_WE=0, WR_READY=0, CLR_BUSY=0; release -> no RAM write until a request arrives.
- Display fetch: preload RAM[a]=a[7:0]; sweep X_IN=0..639, Y_IN=8, VID_ACTIVE=1 -> RAM_ADDR=2*160+(X>>2) in PXL_CLK=1 cycles; PIX_OUT equals the value for the previous pixel's coordinates.
- Write during active video: WR_VALID held with (x=5, y=3, 0xE0) -> WR_READY high only in PXL_CLK=0 cycles; one write of 0xE0 at addr 485.
- Blanking bandwidth: VID_ACTIVE=0, 10 back-to-back writes -> 10 transfers in 10 consecutive cycles.
- Clear: CLR_REQ pulse with CLR_COLOR=0x1C during continuous blanking -> 19200 writes of 0x1C to addresses 0..19199 in order; CLR_BUSY high for 19200 cycles; WR_READY=0 throughout.
- Drop and reset mid-clear: write x=160 -> handshake completes with RAM_WE=0 (DROP_CNT=1 if stats enabled); assert RST_N after 100 clear writes -> CLR_BUSY=0 immediately, no further writes.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg - framebuffer geometry, FSM state and pixel types shared by the arbiter files.
// Revision 1.0
`default_nettype none

package vga_pkg;

   localparam int FB_W        = 160;
   localparam int FB_H        = 120;
   localparam int SCALE_SHIFT = 2;
   localparam int ADDR_W      = 15;
   localparam int PIXEL_W     = 8;
   localparam int FB_SIZE     = FB_W * FB_H;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   typedef logic [PIXEL_W-1:0] pixel_t;

   // Row-major framebuffer address; the multiply is by a constant.
   function automatic logic [ADDR_W-1:0] fb_addr(input logic [ADDR_W-1:0] x,
                                                  input logic [ADDR_W-1:0] y);
      return y * ADDR_W'(FB_W) + x;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vga_fb_clear_seq.sv
// vga_fb_clear_seq - clear-screen FSM and address counter, writes one pixel per granted slot.
// Revision 1.0
`default_nettype none

module vga_fb_clear_seq
   import vga_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               slot_gnt_i,
   input  logic               clr_req_i,
   input  logic [PIXEL_W-1:0] clr_color_i,
   output logic               busy_o,
   output logic               wr_stb_o,
   output logic [ADDR_W-1:0]  addr_o,
   output logic [PIXEL_W-1:0] data_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   pixel_t            color_q, color_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         color_q <= color_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      color_d  = color_q;
      wr_stb_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr_req_i) begin
               color_d = clr_color_i;
               cnt_d   = '0;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            // New requests are not looked at until the fill completes.
            if (slot_gnt_i) begin
               wr_stb_o = 1'b1;
               if (cnt_q == LAST_ADDR) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o = (state_q == CLEAR);
   assign addr_o = cnt_q;
   assign data_o = color_q;

endmodule

`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter - time-slices one framebuffer RAM between VGA fetch, paint writer and clear.
// Revision 1.0. Optional write/drop counters with VGA_FB_ARB_STATS_EN.
`default_nettype none

module vga_fb_arbiter
   import vga_pkg::*;
(
   input  logic               CLK_IN,
   input  logic               RST_N,
   input  logic               PXL_CLK,
   input  logic               VID_ACTIVE,
   input  logic [9:0]         X_IN,
   input  logic [9:0]         Y_IN,
   output logic [PIXEL_W-1:0] PIX_OUT,
   input  logic               WR_VALID,
   output logic               WR_READY,
   input  logic [7:0]         WR_X,
   input  logic [6:0]         WR_Y,
   input  logic [PIXEL_W-1:0] WR_DATA,
   input  logic               CLR_REQ,
   input  logic [PIXEL_W-1:0] CLR_COLOR,
   output logic               CLR_BUSY,
   output logic [ADDR_W-1:0]  RAM_ADDR,
   output logic               RAM_WE,
   output logic [PIXEL_W-1:0] RAM_WDATA,
   input  logic [PIXEL_W-1:0] RAM_RDATA
`ifdef VGA_FB_ARB_STATS_EN
   ,
   output logic [15:0]        WR_CNT,
   output logic [7:0]         DROP_CNT
`endif
);

   localparam logic [7:0] WR_X_LIM = 8'(FB_W);
   localparam logic [6:0] WR_Y_LIM = 7'(FB_H);

   logic              disp_slot;
   logic              wr_slot;
   logic              wr_xfer;
   logic              wr_in_range;
   logic              clr_busy;
   logic              clr_stb;
   logic [ADDR_W-1:0] disp_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] clr_addr;
   pixel_t            clr_data;
   logic              rd_pending_q;
   pixel_t            pix_q, pix_d;

   assign disp_slot = PXL_CLK & VID_ACTIVE;
   assign wr_slot   = ~disp_slot;

   assign disp_addr = fb_addr(ADDR_W'(X_IN >> SCALE_SHIFT), ADDR_W'(Y_IN >> SCALE_SHIFT));
   assign wr_addr   = fb_addr(ADDR_W'(WR_X), ADDR_W'(WR_Y));

   assign wr_in_range = (WR_X < WR_X_LIM) && (WR_Y < WR_Y_LIM);

   // A pending clear request outranks a writer in the same slot.
   assign WR_READY = RST_N & wr_slot & ~clr_busy & ~CLR_REQ;
   assign wr_xfer  = WR_VALID & WR_READY;

   vga_fb_clear_seq u_clear_seq (
      .clk_i       (CLK_IN),
      .rst_ni      (RST_N),
      .slot_gnt_i  (wr_slot),
      .clr_req_i   (CLR_REQ),
      .clr_color_i (CLR_COLOR),
      .busy_o      (clr_busy),
      .wr_stb_o    (clr_stb),
      .addr_o      (clr_addr),
      .data_o      (clr_data)
   );

   assign CLR_BUSY = clr_busy;

   always_comb begin
      RAM_ADDR  = '0;
      RAM_WE    = 1'b0;
      RAM_WDATA = '0;
      if (!RST_N) begin
         RAM_ADDR  = '0;
      end else if (disp_slot) begin
         RAM_ADDR  = disp_addr;
      end else if (clr_stb) begin
         RAM_WE    = 1'b1;
         RAM_ADDR  = clr_addr;
         RAM_WDATA = clr_data;
      end else if (wr_xfer && wr_in_range) begin
         RAM_WE    = 1'b1;
         RAM_ADDR  = wr_addr;
         RAM_WDATA = WR_DATA;
      end
   end

   // Read data lands the cycle after a display slot; blank once the fetch stream stops.
   always_comb begin
      pix_d = pix_q;
      if (rd_pending_q) begin
         pix_d = RAM_RDATA;
      end else if (!PXL_CLK) begin
         pix_d = '0;
      end
   end

   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         rd_pending_q <= 1'b0;
         pix_q        <= '0;
      end else begin
         rd_pending_q <= disp_slot;
         pix_q        <= pix_d;
      end
   end

   assign PIX_OUT = pix_q;

`ifdef VGA_FB_ARB_STATS_EN
   logic [15:0] wr_cnt_q;
   logic [7:0]  drop_cnt_q;

   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         wr_cnt_q   <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (wr_xfer && wr_in_range) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
         end
         if (wr_xfer && !wr_in_range && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
         end
      end
   end

   assign WR_CNT   = wr_cnt_q;
   assign DROP_CNT = drop_cnt_q;
`endif

endmodule

`default_nettype wire
